// File: rtl/scan_register.sv
// Multi-chain scan register: CHAINS independent WIDTH-bit chains with capture,
// shift, hold, a shadow update register and a shift-window counter.
module scan_register #(
    parameter int WIDTH  = 8,
    parameter int CHAINS = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CHAINS*WIDTH-1:0]   DI,
    input  logic [CHAINS-1:0]         SI,
    input  logic                      SE,
    input  logic                      HOLD,
    input  logic                      UPD,
    output logic [CHAINS*WIDTH-1:0]   Q,
    output logic [CHAINS-1:0]         SO,
    output logic [CHAINS*WIDTH-1:0]   DO,
    output logic [$clog2(WIDTH)-1:0]  SHIFT_CNT,
    output logic                      SHIFT_DONE
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [CHAINS*WIDTH-1:0] q_q, q_d;
    logic [CHAINS*WIDTH-1:0] do_q, do_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    done_q, done_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        q_d    = q_q;
        do_d   = do_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;

        if (HOLD) begin
            q_d   = q_q;
            cnt_d = cnt_q;
        end else if (SE) begin
            for (int c = 0; c < CHAINS; c++) begin
                q_d[c*WIDTH +: WIDTH] = {SI[c], q_q[c*WIDTH+1 +: WIDTH-1]};
            end
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            q_d   = DI;
            cnt_d = '0;
        end

        // Shadow loads the pre-edge contents; a pattern in motion never reaches DO.
        if (UPD && !SE) begin
            do_d = q_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q    <= '0;
            do_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            do_q   <= do_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        for (int c = 0; c < CHAINS; c++) begin
            SO[c] = q_q[c*WIDTH];
        end
    end

    assign Q          = q_q;
    assign DO         = do_q;
    assign SHIFT_CNT  = cnt_q;
    assign SHIFT_DONE = done_q;

endmodule

// File: doc/scan_register.md
# scan_register

Parametrised multi-chain scan register with capture, shift, hold and update modes, a shift-length counter and a shadow update stage. It generalises the single scan D flip-flop into CHAINS independent chains of WIDTH cells. These chains share one scan-enable. A shadow output register keeps the functional outputs stable while a pattern is shifted. The block sits between the combinational circuit-under-test and the tester interface, and provides load, unload and apply of test patterns.

## Interface
- WIDTH, 8: cells per chain; must be ≥2.
- CHAINS, 2: number of parallel scan chains; must be ≥1.
- CLK  input  1  single clock; all state changes on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- DI  input  CHAINS*WIDTH  functional capture data; chain c uses bits [c*WIDTH +: WIDTH].
- SI  input  CHAINS  serial scan-in, one bit per chain.
- SE  input  1  scan enable: 1 = shift, 0 = capture.
- HOLD  input  1  freezes the capture register and the counter.
- UPD  input  1  copies the capture register into the shadow register.
- Q  output  CHAINS*WIDTH  capture/shift register contents.
- SO  output  CHAINS  serial scan-out; bit 0 of each chain.
- DO  output  CHAINS*WIDTH  shadow (update) register; drives the functional side.
- SHIFT_CNT  output  $clog2(WIDTH)  shift cycles completed in the current unload window.
- SHIFT_DONE  output  1  one-cycle pulse after each full WIDTH-shift window.

## Operation
- Per-edge priority for the capture register Q: RST > HOLD > SE=1 (shift) > SE=0 (capture).
- **RST=1:** Q, DO, SHIFT_CNT and SHIFT_DONE all become 0.
- **HOLD=1:** Q and SHIFT_CNT keep their values. SHIFT_DONE goes to 0. UPD is still honoured.
- **Shift (SE=1, HOLD=0):**
  - Each chain shifts right by one: bit i takes bit i+1.
  - Bit WIDTH-1 takes SI[c].
  - The old bit 0 is lost; it was already visible on SO[c].
  - Chains shift simultaneously and independently.
- **Capture (SE=0, HOLD=0):** Q takes DI. SHIFT_CNT clears to 0.
- **SO[c]:** equals Q[c*WIDTH], a direct wire from a register; no extra flop.
- **Update register DO:**
  - Loads Q, as it was before the edge, when UPD=1, SE=0 and RST=0.
  - UPD is ignored while SE=1, so a pattern in motion never reaches DO.
  - DO holds otherwise.
- **Counter:**
  - Increments on every shift edge.
  - On a shift edge with SHIFT_CNT = WIDTH-1, it wraps to 0 and SHIFT_DONE is set to 1 for the next cycle.
  - SHIFT_DONE is 0 on every other edge.
- **Simultaneous events:**
  - HOLD with SE=1: HOLD wins; no shift and no count.
  - UPD with capture: DO gets the old Q, while Q gets DI on the same edge.
  - RST mid-shift aborts the window. The counter restarts from 0 when shifting resumes.

## Timing
- All outputs are registered or are direct register bits. There is no combinational path from input to output.
- Q / SO latency: one edge after SE/SI/DI are sampled.
- DO latency: one edge after UPD.
- SHIFT_DONE is high during the cycle that follows the WIDTH-th consecutive shift edge. Unloading one full chain therefore takes WIDTH edges.
- Reset values: Q=0, SO=0, DO=0, SHIFT_CNT=0, SHIFT_DONE=0.
- Inputs are sampled only at the rising edge of CLK. Changing SE between edges has no intermediate effect.

## Test plan
All scenarios use WIDTH=4 and CHAINS=2.

- **Reset:** drive RST=1 for 2 edges with DI=8'hFF, SE=0 → Q=0, DO=0, SO=2'b00, SHIFT_CNT=0, SHIFT_DONE=0.
- **Capture and update:**
  - Apply SE=0, DI=8'hA5 for one edge → Q=8'hA5, SO=2'b01, DO=0.
  - Then apply UPD=1 for one edge → DO=8'hA5.
- **Shift and unload:**
  - Capture 8'hA5.
  - Apply SE=1, SI=2'b11 for 4 edges.
  - Required SO sequence starting after the capture edge: chain 0 = 1,0,1,0; chain 1 = 0,1,0,1.
  - After the 4th edge: Q=8'hFF and SHIFT_DONE=1 for exactly one cycle.
- **Hold priority:**
  - After 2 shift edges (SHIFT_CNT=2), apply SE=1, HOLD=1 for 3 edges → Q and SHIFT_CNT unchanged, SHIFT_DONE=0.
  - Release HOLD → after 2 more shift edges, SHIFT_DONE pulses.
- **UPD during shift:** with DO=8'hA5, apply SE=1, UPD=1 for 4 edges → DO stays 8'hA5.
- **Reset mid-shift:**
  - Apply RST=1 after 3 shift edges → all outputs 0.
  - After RST is released, 4 shift edges are needed before SHIFT_DONE pulses.
